seq_shift_rotate: RTL and testbench

- Multi-cycle parametrised shift/rotate unit; next generation of the team's universal shift register.
- Adds logical, arithmetic and rotate modes, a programmable shift amount, and a bounded shift step per cycle.
- Uses a start/busy/done handshake so that sequencers (e.g. shift-add multiplier control) can issue whole shift operations as single commands.

---
 rtl/seq_shift_rotate.sv | 135 +++++++++++++
 tb/tb_seq_shift_rotate.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_rotate.sv
// Multi-cycle shift/rotate unit: logical, arithmetic and rotate modes.
// Shifts at most STEP positions per clock under a start/busy/done handshake.
module seq_shift_rotate #(
  parameter int N    = 8,
  parameter int STEP = 2,
  parameter int AW   = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amount,
  input  logic [N-1:0]  data_in,
  input  logic          ser_in,
  output logic [N-1:0]  data_out,
  output logic          ser_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic          ser_q, ser_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [2:0]    op_q, op_d;
  logic          fill_q, fill_d;
  logic          busy_q, done_q;

  logic [AW-1:0] k;
  logic [N-1:0]  sh;
  logic          sh_so;

  // A k-position step is built as k chained single-bit steps.
  always_comb begin
    k     = (rem_q < AW'(STEP)) ? rem_q : AW'(STEP);
    sh    = data_q;
    sh_so = ser_q;
    for (int i = 0; i < STEP; i++) begin
      if (AW'(i) < k) begin
        case (op_q)
          OP_LSL: begin
            sh_so = sh[N-1];
            sh    = {sh[N-2:0], fill_q};
          end
          OP_LSR: begin
            sh_so = sh[0];
            sh    = {fill_q, sh[N-1:1]};
          end
          OP_ASR: begin
            sh_so = sh[0];
            sh    = {sh[N-1], sh[N-1:1]};
          end
          OP_ROL: begin
            sh_so = sh[N-1];
            sh    = {sh[N-2:0], sh[N-1]};
          end
          OP_ROR: begin
            sh_so = sh[0];
            sh    = {sh[0], sh[N-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ser_d   = ser_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          op_d    = op;
          fill_d  = ser_in;
          ser_d   = 1'b0;
          rem_d   = (amount > AW'(N)) ? AW'(N) : amount;
          state_d = (amount != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        data_d = sh;
        ser_d  = sh_so;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      rem_q   <= '0;
      op_q    <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_shift_rotate.sv
// Randomized self-checking bench for seq_shift_rotate.
// Reference model computes whole operations arithmetically.
module tb_seq_shift_rotate;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int AW   = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amount;
  logic [N-1:0]  data_in;
  logic          ser_in;
  logic [N-1:0]  data_out;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_rotate #(.N(N), .STEP(STEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .data_in  (data_in),
    .ser_in   (ser_in),
    .data_out (data_out),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-operation result: shift amount a applied at once.
  function automatic void model(input logic [2:0] o, input logic [7:0] d,
                                input logic [3:0] amt, input logic s,
                                output logic [7:0] r, output logic so,
                                output int cyc);
    int a;
    logic [15:0] w;
    logic [15:0] m;
    logic [7:0]  ff;
    a   = (amt > 4'd8) ? 8 : int'(amt);
    cyc = (a + STEP - 1) / STEP;
    ff  = 8'hFF;
    so  = 1'b0;
    case (o)
      3'd0: begin
        w = {8'h00, d} << a;
        m = (16'd1 << a) - 16'd1;
        r = w[7:0] | (s ? m[7:0] : 8'h00);
        if (a > 0) so = d[8-a];
      end
      3'd1: begin
        r = (d >> a) | (s ? ~(ff >> a) : 8'h00);
        if (a > 0) so = d[a-1];
      end
      3'd2: begin
        r = 8'($signed(d) >>> a);
        if (a > 0) so = d[a-1];
      end
      3'd3: begin
        w = {d, d} << a;
        r = w[15:8];
        if (a > 0) so = r[0];
      end
      3'd4: begin
        w = {d, d} >> a;
        r = w[7:0];
        if (a > 0) so = r[7];
      end
      default: r = d;
    endcase
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input logic [2:0] o, input logic [7:0] d,
                        input logic [3:0] a, input logic s, input bit inj);
    logic [7:0] er;
    logic       es;
    int         kc;
    int         edges;
    bit         busy_ok;
    model(o, d, a, s, er, es, kc);
    start   = 1'b1;
    op      = o;
    data_in = d;
    amount  = a;
    ser_in  = s;
    @(posedge clk); #1;
    start   = 1'b0;
    edges   = 1;
    busy_ok = 1'b1;
    while (!done && edges < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (inj) begin
        start   = 1'b1;
        data_in = 8'($urandom);
        op      = 3'($urandom);
        amount  = 4'($urandom);
        ser_in  = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    if (!busy) busy_ok = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(edges), 32'(kc + 1));
    chk("busy_run", 32'(busy_ok), 32'd1);
    chk("data", 32'(data_out), 32'(er));
    chk("ser", 32'(ser_out), 32'(es));
    if (inj) begin
      start   = 1'b1;
      data_in = ~d;
      amount  = 4'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("data_hold", 32'(data_out), 32'(er));
    chk("ser_hold", 32'(ser_out), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    op      = '0;
    amount  = '0;
    data_in = '0;
    ser_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_ser", 32'(ser_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 8'hB3, 4'd3, 1'b0, 1'b0);
    chk("s1_const", 32'(data_out), 32'h98);
    run_op(3'd2, 8'h84, 4'd5, 1'b0, 1'b0);
    chk("s2_const", 32'(data_out), 32'hFC);
    run_op(3'd4, 8'h81, 4'd1, 1'b0, 1'b0);
    chk("s3_ror", 32'(data_out), 32'hC0);
    run_op(3'd3, 8'h5A, 4'd8, 1'b0, 1'b0);
    chk("s3_rol", 32'(data_out), 32'h5A);
    run_op(3'd1, 8'hFF, 4'd12, 1'b0, 1'b0);
    chk("s4_lsr", 32'(data_out), 32'h00);
    run_op(3'd1, 8'h3C, 4'd0, 1'b1, 1'b0);
    run_op(3'd0, 8'hB3, 4'd3, 1'b0, 1'b1);
    chk("s5_const", 32'(data_out), 32'h98);

    start   = 1'b1;
    op      = 3'd2;
    data_in = 8'h84;
    amount  = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_ser", 32'(ser_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_op(3'd2, 8'h84, 4'd5, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
